// File: rtl/nap_axi_burst_master_if.sv
// AXI4 bundle between the burst master and the NAP slave wrapper.
// Only the fields the burst master drives or checks are carried.
interface nap_axi_burst_master_if #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 42
);
  logic [7:0]              awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awlock;
  logic [3:0]              awqos;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [7:0]              bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [7:0]              arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arlock;
  logic [3:0]              arqos;
  logic                    arvalid;
  logic                    arready;

  logic [7:0]              rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arqos, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arqos, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/nap_axi_burst_master.sv
// Writes NUM_BURSTS INCR bursts of a burst/beat/lane tagged pattern through the NAP,
// reads the region back, and counts every failed response or data check.
module nap_axi_burst_master #(
  parameter int                    DATA_WIDTH = 256,
  parameter int                    ADDR_WIDTH = 42,
  parameter logic [7:0]            BURST_LEN  = 8'd15,
  parameter int                    NUM_BURSTS = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter logic [7:0]            AXI_ID     = 8'h00
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  nap_axi_burst_master_if.master nap,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_fail,
  output logic [15:0]           o_error_count,
  output logic [15:0]           o_bursts_done
);

  localparam int                    NUM_LANES   = DATA_WIDTH / 32;
  localparam int                    BEAT_BYTES  = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'((int'(BURST_LEN) + 1) * BEAT_BYTES);
  localparam logic [2:0]            AX_SIZE     = 3'($clog2(BEAT_BYTES));
  localparam logic [15:0]           LAST_BURST  = 16'(NUM_BURSTS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_ADDR, S_WR_DATA, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_DONE
  } state_t;

  state_t                  state_reg;
  logic                    awvalid_reg, wvalid_reg, wlast_reg, bready_reg;
  logic                    arvalid_reg, rready_reg;
  logic                    busy_reg, done_reg, fail_reg;
  logic [15:0]             err_count_reg, bursts_done_reg, burst_idx_reg;
  logic [7:0]              beat_idx_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [DATA_WIDTH-1:0]   wdata_reg;

  logic [7:0]              wr_next_beat;
  logic [DATA_WIDTH-1:0]   wr_next_data, rd_expect;
  logic                    rd_last_beat, b_err;
  logic [2:0]              rd_err_inc, err_inc;
  logic [16:0]             err_sum;
  logic [15:0]             err_next;

  // WR_ADDR preloads beat 0; during WR_DATA the next beat is prepared on each accept.
  assign wr_next_beat = (state_reg == S_WR_ADDR) ? 8'd0 : beat_idx_reg + 8'd1;
  assign rd_last_beat = (beat_idx_reg == BURST_LEN);

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    assign wr_next_data[32*gi +: 32] = {burst_idx_reg, wr_next_beat, 8'(gi)};
    assign rd_expect[32*gi +: 32]    = {burst_idx_reg, beat_idx_reg, 8'(gi)};
  end

  assign b_err      = (nap.bresp != 2'b00) || (nap.bid != AXI_ID);
  assign rd_err_inc = {2'b00, (nap.rdata != rd_expect)}
                    + {2'b00, (nap.rresp != 2'b00)}
                    + {2'b00, (nap.rid != AXI_ID)}
                    + {2'b00, (nap.rlast != rd_last_beat)};

  always_comb begin
    err_inc = 3'd0;
    if (state_reg == S_WR_RESP && nap.bvalid) begin
      err_inc = {2'b00, b_err};
    end else if (state_reg == S_RD_DATA && nap.rvalid) begin
      err_inc = rd_err_inc;
    end
    err_sum  = {1'b0, err_count_reg} + {14'd0, err_inc};
    err_next = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg       <= S_IDLE;
      awvalid_reg     <= 1'b0;
      wvalid_reg      <= 1'b0;
      wlast_reg       <= 1'b0;
      bready_reg      <= 1'b0;
      arvalid_reg     <= 1'b0;
      rready_reg      <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      fail_reg        <= 1'b0;
      err_count_reg   <= 16'd0;
      bursts_done_reg <= 16'd0;
      burst_idx_reg   <= 16'd0;
      beat_idx_reg    <= 8'd0;
      addr_reg        <= BASE_ADDR;
      wdata_reg       <= '0;
    end else begin
      case (state_reg)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            state_reg       <= S_WR_ADDR;
            awvalid_reg     <= 1'b1;
            busy_reg        <= 1'b1;
            done_reg        <= 1'b0;
            fail_reg        <= 1'b0;
            err_count_reg   <= 16'd0;
            bursts_done_reg <= 16'd0;
            burst_idx_reg   <= 16'd0;
            beat_idx_reg    <= 8'd0;
            addr_reg        <= BASE_ADDR;
          end
        end
        S_WR_ADDR: begin
          if (nap.awready) begin
            awvalid_reg  <= 1'b0;
            wvalid_reg   <= 1'b1;
            wdata_reg    <= wr_next_data;
            wlast_reg    <= (BURST_LEN == 8'd0);
            beat_idx_reg <= 8'd0;
            state_reg    <= S_WR_DATA;
          end
        end
        S_WR_DATA: begin
          if (nap.wready) begin
            if (wlast_reg) begin
              wvalid_reg <= 1'b0;
              wlast_reg  <= 1'b0;
              bready_reg <= 1'b1;
              state_reg  <= S_WR_RESP;
            end else begin
              beat_idx_reg <= beat_idx_reg + 8'd1;
              wdata_reg    <= wr_next_data;
              wlast_reg    <= (beat_idx_reg + 8'd1 == BURST_LEN);
            end
          end
        end
        S_WR_RESP: begin
          if (nap.bvalid) begin
            bready_reg    <= 1'b0;
            err_count_reg <= err_next;
            if (burst_idx_reg == LAST_BURST) begin
              // Read phase restarts the address walk and the burst counter.
              burst_idx_reg   <= 16'd0;
              bursts_done_reg <= 16'd0;
              addr_reg        <= BASE_ADDR;
              arvalid_reg     <= 1'b1;
              state_reg       <= S_RD_ADDR;
            end else begin
              burst_idx_reg   <= burst_idx_reg + 16'd1;
              bursts_done_reg <= bursts_done_reg + 16'd1;
              addr_reg        <= addr_reg + BURST_BYTES;
              awvalid_reg     <= 1'b1;
              state_reg       <= S_WR_ADDR;
            end
          end
        end
        S_RD_ADDR: begin
          if (nap.arready) begin
            arvalid_reg  <= 1'b0;
            rready_reg   <= 1'b1;
            beat_idx_reg <= 8'd0;
            state_reg    <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (nap.rvalid) begin
            err_count_reg <= err_next;
            // An early rlast still closes the burst; the missing beats are not waited for.
            if (nap.rlast || rd_last_beat) begin
              rready_reg      <= 1'b0;
              bursts_done_reg <= bursts_done_reg + 16'd1;
              if (burst_idx_reg == LAST_BURST) begin
                busy_reg  <= 1'b0;
                done_reg  <= 1'b1;
                fail_reg  <= (err_next != 16'd0);
                state_reg <= S_DONE;
              end else begin
                burst_idx_reg <= burst_idx_reg + 16'd1;
                addr_reg      <= addr_reg + BURST_BYTES;
                arvalid_reg   <= 1'b1;
                state_reg     <= S_RD_ADDR;
              end
            end else begin
              beat_idx_reg <= beat_idx_reg + 8'd1;
            end
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign nap.awid    = AXI_ID;
  assign nap.awaddr  = addr_reg;
  assign nap.awlen   = BURST_LEN;
  assign nap.awsize  = AX_SIZE;
  assign nap.awburst = 2'b01;
  assign nap.awlock  = 1'b0;
  assign nap.awqos   = 4'd0;
  assign nap.awvalid = awvalid_reg;

  assign nap.wdata   = wdata_reg;
  assign nap.wstrb   = '1;
  assign nap.wlast   = wlast_reg;
  assign nap.wvalid  = wvalid_reg;
  assign nap.bready  = bready_reg;

  assign nap.arid    = AXI_ID;
  assign nap.araddr  = addr_reg;
  assign nap.arlen   = BURST_LEN;
  assign nap.arsize  = AX_SIZE;
  assign nap.arburst = 2'b01;
  assign nap.arlock  = 1'b0;
  assign nap.arqos   = 4'd0;
  assign nap.arvalid = arvalid_reg;
  assign nap.rready  = rready_reg;

  assign o_busy        = busy_reg;
  assign o_done        = done_reg;
  assign o_fail        = fail_reg;
  assign o_error_count = err_count_reg;
  assign o_bursts_done = bursts_done_reg;

endmodule

// File: tb/tb_nap_axi_burst_master.sv
// Bench for nap_axi_burst_master: memory-model AXI slave with random backpressure
// and fault injection, table of pass scenarios, plus a mid-pass reset sequence.
module tb_nap_axi_burst_master;
  localparam int             DW    = 64;
  localparam int             AW    = 42;
  localparam int             BL    = 3;
  localparam int             NB    = 2;
  localparam int             BEATS = BL + 1;
  localparam int             BYTES = DW / 8;
  localparam logic [AW-1:0]  BASE  = 42'h1000;
  localparam logic [7:0]     ID    = 8'h05;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_start = 1'b0;
  logic        o_busy, o_done, o_fail;
  logic [15:0] o_error_count, o_bursts_done;

  nap_axi_burst_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) nap ();

  nap_axi_burst_master #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(8'(BL)), .NUM_BURSTS(NB),
    .BASE_ADDR(BASE), .AXI_ID(ID)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .nap(nap),
    .o_busy(o_busy), .o_done(o_done), .o_fail(o_fail),
    .o_error_count(o_error_count), .o_bursts_done(o_bursts_done)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    string name;
    int    ready_pct;
    bit    corrupt;
    bit    rand_loc;
    bit    bresp_err;
    bit    rresp_err;
    bit    early;
    bit    start_mid;
    int    exp_err;
    bit    exp_fail;
    int    exp_r;
  } vec_t;

  int tests = 0;
  int failed = 0;

  // Slave configuration and state
  int  cfg_ready_pct = 100;
  bit  cfg_corrupt, cfg_bresp_err, cfg_rresp_err, cfg_early;
  int  cfg_c_burst, cfg_c_beat, cfg_c_bit;
  bit  slave_rst = 1'b1;

  logic [DW-1:0] mem [longint];
  longint aw_q[$], ar_q[$], aw_addrs[$], ar_addrs[$];
  int  w_beat, b_pend, b_num, r_beat, r_burst;
  bit  r_act;
  longint r_addr;
  int  aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  int  viol_stable, viol_proto, viol_wlast, viol_field;

  bit  s_awv, s_awr, s_wv, s_wr, s_wlast, s_bv, s_br, s_arv, s_arr, s_rv, s_rr, s_rlast;
  longint s_awaddr, s_araddr;
  logic [DW-1:0] s_wdata;

  function automatic logic [DW-1:0] ref_pat(int n, int b);
    logic [DW-1:0] p;
    for (int k = 0; k < DW / 32; k++) p[32*k +: 32] = 32'((n << 16) + (b << 8) + k);
    return p;
  endfunction

  function automatic longint burst_addr(int n);
    return longint'(BASE) + longint'(n * BEATS * BYTES);
  endfunction

  function automatic bit rnd(int pct);
    return int'($urandom_range(99)) < pct;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Memory-model AXI slave: handshakes seen in the previous snapshot are retired,
  // then new READY/response values are driven for the next rising edge.
  initial begin : slave
    longint ra;
    logic [DW-1:0] rd;
    nap.awready = 0; nap.wready = 0; nap.arready = 0;
    nap.bvalid = 0; nap.bid = 0; nap.bresp = 0;
    nap.rvalid = 0; nap.rid = 0; nap.rdata = '0; nap.rresp = 0; nap.rlast = 0;
    forever begin
      @(negedge i_clk);
      if (slave_rst) begin
        aw_q.delete(); ar_q.delete(); aw_addrs.delete(); ar_addrs.delete(); mem.delete();
        w_beat = 0; b_pend = 0; b_num = 0; r_beat = 0; r_burst = 0; r_act = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        viol_stable = 0; viol_proto = 0; viol_wlast = 0; viol_field = 0;
        nap.awready = 0; nap.wready = 0; nap.arready = 0; nap.bvalid = 0; nap.rvalid = 0;
        {s_awv, s_awr, s_wv, s_wr, s_wlast, s_bv, s_br, s_arv, s_arr, s_rv, s_rr, s_rlast} = '0;
      end else begin
        if (s_awv && !s_awr && (!nap.awvalid || longint'(nap.awaddr) != s_awaddr)) viol_stable++;
        if (s_wv && !s_wr && (!nap.wvalid || nap.wdata != s_wdata || nap.wlast != s_wlast)) viol_stable++;
        if (s_arv && !s_arr && (!nap.arvalid || longint'(nap.araddr) != s_araddr)) viol_stable++;

        if (s_bv && s_br) begin b_cnt++; b_pend--; b_num++; end
        if (s_rv && s_rr) begin
          r_cnt++; r_beat++;
          if (s_rlast) begin r_act = 0; r_burst++; end
        end
        if (s_awv && s_awr) begin
          aw_cnt++;
          if (aw_q.size() != 0 || b_pend != 0 || r_act || ar_q.size() != 0) viol_proto++;
          aw_q.push_back(s_awaddr); aw_addrs.push_back(s_awaddr);
        end
        if (s_wv && s_wr) begin
          w_cnt++;
          if (aw_q.size() == 0) viol_proto++;
          else begin
            mem[aw_q[0] + longint'(w_beat * BYTES)] = s_wdata;
            if (s_wlast != (w_beat == BL)) viol_wlast++;
            w_beat++;
            if (s_wlast) begin void'(aw_q.pop_front()); w_beat = 0; b_pend++; end
          end
        end
        if (s_arv && s_arr) begin
          ar_cnt++;
          if (aw_q.size() != 0 || b_pend != 0 || r_act || ar_q.size() != 0) viol_proto++;
          ar_q.push_back(s_araddr); ar_addrs.push_back(s_araddr);
        end

        nap.awready = rnd(cfg_ready_pct);
        nap.wready  = rnd(cfg_ready_pct);
        nap.arready = rnd(cfg_ready_pct);
        if (!(s_bv && !s_br)) begin
          if (b_pend > 0 && rnd(cfg_ready_pct)) begin
            nap.bvalid = 1; nap.bid = ID;
            nap.bresp = (cfg_bresp_err && b_num == 0) ? 2'b10 : 2'b00;
          end else nap.bvalid = 0;
        end
        if (!(s_rv && !s_rr)) begin
          if (!r_act && ar_q.size() > 0) begin r_act = 1; r_addr = ar_q.pop_front(); r_beat = 0; end
          if (r_act && rnd(cfg_ready_pct)) begin
            ra = r_addr + longint'(r_beat * BYTES);
            rd = mem.exists(ra) ? mem[ra] : '0;
            if (cfg_corrupt && r_burst == cfg_c_burst && r_beat == cfg_c_beat) rd[cfg_c_bit] = ~rd[cfg_c_bit];
            nap.rdata = rd; nap.rid = ID;
            nap.rresp = (cfg_rresp_err && r_burst == 1 && r_beat == 2) ? 2'b11 : 2'b00;
            nap.rlast = (r_beat == BL) || (cfg_early && r_burst == 0 && r_beat == 1);
            nap.rvalid = 1;
          end else nap.rvalid = 0;
        end

        s_awv = nap.awvalid; s_awr = nap.awready; s_awaddr = longint'(nap.awaddr);
        s_wv = nap.wvalid; s_wr = nap.wready; s_wdata = nap.wdata; s_wlast = nap.wlast;
        s_bv = nap.bvalid; s_br = nap.bready;
        s_arv = nap.arvalid; s_arr = nap.arready; s_araddr = longint'(nap.araddr);
        s_rv = nap.rvalid; s_rr = nap.rready; s_rlast = nap.rlast;
        if (nap.awvalid && (nap.awlen != 8'(BL) || nap.awsize != 3'd3 || nap.awburst != 2'b01 ||
            nap.awid != ID || nap.awlock || nap.awqos != 4'd0)) viol_field++;
        if (nap.arvalid && (nap.arlen != 8'(BL) || nap.arsize != 3'd3 || nap.arburst != 2'b01 ||
            nap.arid != ID || nap.arlock || nap.arqos != 4'd0)) viol_field++;
        if (nap.wvalid && nap.wstrb != '1) viol_field++;
      end
    end
  end

  task automatic clear_slave();
    @(negedge i_clk); slave_rst = 1;
    @(negedge i_clk); @(negedge i_clk); slave_rst = 0;
  endtask

  task automatic run_pass(input vec_t v);
    int cyc, mem_bad, addr_bad;
    clear_slave();
    cfg_ready_pct = v.ready_pct; cfg_corrupt = v.corrupt; cfg_bresp_err = v.bresp_err;
    cfg_rresp_err = v.rresp_err; cfg_early = v.early;
    if (v.rand_loc) begin
      cfg_c_burst = int'($urandom_range(NB - 1)); cfg_c_beat = int'($urandom_range(BL));
      cfg_c_bit = int'($urandom_range(DW - 1));
    end else begin
      cfg_c_burst = 1; cfg_c_beat = 1; cfg_c_bit = int'($urandom_range(31));
    end
    @(negedge i_clk); i_start = 1;
    @(negedge i_clk); i_start = 0;
    check({v.name, " busy_awvalid_done_after_start"}, {o_busy, nap.awvalid, o_done}, 3'b110);
    cyc = 0;
    while (!o_done && cyc < 5000) begin
      @(negedge i_clk); cyc++;
      i_start = (v.start_mid && cyc == 10);
    end
    i_start = 0;
    @(negedge i_clk);
    check({v.name, " done"}, o_done, 1);
    check({v.name, " busy"}, o_busy, 0);
    check({v.name, " fail"}, o_fail, v.exp_fail);
    check({v.name, " error_count"}, o_error_count, v.exp_err);
    check({v.name, " bursts_done"}, o_bursts_done, NB);
    check({v.name, " aw_count"}, aw_cnt, NB);
    check({v.name, " w_count"}, w_cnt, NB * BEATS);
    check({v.name, " b_count"}, b_cnt, NB);
    check({v.name, " ar_count"}, ar_cnt, NB);
    check({v.name, " r_count"}, r_cnt, v.exp_r);
    check({v.name, " stall_stability"}, viol_stable, 0);
    check({v.name, " ordering"}, viol_proto, 0);
    check({v.name, " wlast_position"}, viol_wlast, 0);
    check({v.name, " ax_fields"}, viol_field, 0);
    mem_bad = 0; addr_bad = 0;
    for (int n = 0; n < NB; n++)
      for (int b = 0; b < BEATS; b++)
        if (!mem.exists(burst_addr(n) + longint'(b * BYTES)) ||
            mem[burst_addr(n) + longint'(b * BYTES)] != ref_pat(n, b)) mem_bad++;
    if (aw_addrs.size() != NB || ar_addrs.size() != NB) addr_bad++;
    else for (int n = 0; n < NB; n++)
      if (aw_addrs[n] != burst_addr(n) || ar_addrs[n] != burst_addr(n)) addr_bad++;
    check({v.name, " written_pattern"}, mem_bad, 0);
    check({v.name, " burst_addresses"}, addr_bad, 0);
    $display("[TB] pass %s: cycles=%0d err=%0d fail=%0d r_beats=%0d", v.name, cyc, o_error_count, o_fail, r_cnt);
  endtask

  initial begin : main
    vec_t vecs[6];
    vec_t clean;
    int cyc;
    vecs[0] = '{"clean",        100, 0, 0, 0, 0, 0, 0, 0, 0, NB * BEATS};
    vecs[1] = '{"backpressure",  50, 0, 0, 0, 0, 0, 1, 0, 0, NB * BEATS};
    vecs[2] = '{"corrupt_lane0",100, 1, 0, 0, 0, 0, 0, 1, 1, NB * BEATS};
    vecs[3] = '{"resp_errors",  100, 0, 0, 1, 1, 0, 0, 2, 1, NB * BEATS};
    vecs[4] = '{"early_rlast",   70, 0, 0, 0, 0, 1, 0, 1, 1, NB * BEATS - (BEATS - 2)};
    vecs[5] = '{"random_flip",   50, 1, 1, 0, 0, 0, 1, 1, 1, NB * BEATS};
    clean = vecs[0];

    repeat (3) @(negedge i_clk);
    check("reset busy_done_fail", {o_busy, o_done, o_fail}, 0);
    check("reset error_count", o_error_count, 0);
    check("reset bursts_done", o_bursts_done, 0);
    check("reset valid_ready", {nap.awvalid, nap.wvalid, nap.bready, nap.arvalid, nap.rready}, 0);
    i_reset = 0; slave_rst = 0;
    repeat (3) @(negedge i_clk);
    check("idle quiet", {o_busy, nap.awvalid, nap.wvalid, nap.arvalid}, 0);

    for (int i = 0; i < 6; i++) run_pass(vecs[i]);

    // Reset in the middle of a write burst, then a clean pass must follow.
    clear_slave();
    cfg_ready_pct = 100; cfg_corrupt = 0; cfg_bresp_err = 0; cfg_rresp_err = 0; cfg_early = 0;
    @(negedge i_clk); i_start = 1;
    @(negedge i_clk); i_start = 0;
    cyc = 0;
    while (w_cnt < 2 && cyc < 200) begin @(negedge i_clk); cyc++; end
    check("mid_reset reached_wr_data", nap.wvalid, 1);
    i_reset = 1; slave_rst = 1;
    @(negedge i_clk);
    check("mid_reset valids_low", {nap.awvalid, nap.wvalid, nap.bready, nap.arvalid, nap.rready}, 0);
    check("mid_reset busy_low", o_busy, 0);
    @(negedge i_clk); i_reset = 0; slave_rst = 0;
    $display("[TB] mid-pass reset applied after %0d cycles", cyc);
    clean.name = "after_reset";
    run_pass(clean);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
